// File: rtl/fft_sample_loader.sv
// fft_sample_loader
//   Upstream stage of the FFT core. Accepts a stream of real samples over a
//   valid/ready handshake and writes each one into the shared sample SRAM at
//   its bit-reversed complex slot ({rev(k),0} = real, {rev(k),1} = imag = 0).
//   When a full frame of N = 2^LOG2N points is loaded it pulses fft_start,
//   hands the SRAM bus to the core, waits for fft_done, then takes the bus
//   back and accepts the next frame. Samples offered while the FFT is in
//   flight are dropped and counted in a saturating counter.
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   sample_in      real sample (two's complement)
//   sample_valid   sample_in valid this cycle
//   sample_ready   loader accepts sample_in this cycle (FILL_RE only)
//   fft_done       FFT-complete pulse from the core (honoured in WAIT_DONE)
//   fft_start      one-cycle start pulse to the core (registered)
//   sram_write_ena SRAM write strobe (registered)
//   sram_addr      SRAM word address (registered), ADDR_W = LOG2N+1
//   sram_wdata     SRAM write data (registered)
//   bus_owner      1 = loader owns the SRAM bus, 0 = FFT core owns it
//   busy           FFT in flight (START or WAIT_DONE)
//   drop_count     saturating count of samples lost while busy
module fft_sample_loader #(
    parameter int LOG2N  = 9,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              sample_ready,
    input  logic              fft_done,
    output logic              fft_start,
    output logic              sram_write_ena,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              bus_owner,
    output logic              busy,
    output logic [DROP_W-1:0] drop_count
);

    typedef enum logic [1:0] {
        FILL_RE,
        FILL_IM,
        START,
        WAIT_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [LOG2N-1:0]  cnt, cnt_nxt, cnt_rev;
    logic              we_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic              start_nxt;
    logic              owner_nxt;
    logic [DROP_W-1:0] drop_nxt;
    logic              transfer;

    assign sample_ready = (state == FILL_RE);
    assign busy         = (state == START) || (state == WAIT_DONE);
    assign transfer     = sample_valid && sample_ready;

    // Bit-reversed sample index selects the complex slot.
    always_comb begin
        cnt_rev = '0;
        for (int unsigned i = 0; i < LOG2N; i++) begin
            cnt_rev[i] = cnt[LOG2N-1-i];
        end
    end

    // Next-state and next values for every registered output. The registers
    // below simply load these, so each write appears one cycle after the
    // state that decided it.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        we_nxt    = 1'b0;
        addr_nxt  = sram_addr;
        wdata_nxt = sram_wdata;
        start_nxt = 1'b0;
        owner_nxt = bus_owner;
        drop_nxt  = drop_count;

        if (busy && sample_valid && (drop_count != '1)) begin
            drop_nxt = drop_count + 1'b1;
        end

        case (state)
            FILL_RE: begin
                if (transfer) begin
                    we_nxt    = 1'b1;
                    addr_nxt  = {cnt_rev, 1'b0};
                    wdata_nxt = sample_in;
                    state_nxt = FILL_IM;
                end
            end
            FILL_IM: begin
                we_nxt    = 1'b1;
                addr_nxt  = {cnt_rev, 1'b1};
                wdata_nxt = '0;
                if (cnt == '1) begin
                    cnt_nxt   = '0;
                    state_nxt = START;
                end else begin
                    cnt_nxt   = cnt + 1'b1;
                    state_nxt = FILL_RE;
                end
            end
            START: begin
                // fft_done here is deliberately ignored.
                start_nxt = 1'b1;
                owner_nxt = 1'b0;
                state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (fft_done) begin
                    owner_nxt = 1'b1;
                    state_nxt = FILL_RE;
                end
            end
            default: begin
                state_nxt = FILL_RE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= FILL_RE;
            cnt            <= '0;
            sram_write_ena <= 1'b0;
            sram_addr      <= '0;
            sram_wdata     <= '0;
            fft_start      <= 1'b0;
            bus_owner      <= 1'b1;
            drop_count     <= '0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            sram_write_ena <= we_nxt;
            sram_addr      <= addr_nxt;
            sram_wdata     <= wdata_nxt;
            fft_start      <= start_nxt;
            bus_owner      <= owner_nxt;
            drop_count     <= drop_nxt;
        end
    end

endmodule

// File: tb/tb_fft_sample_loader.sv
// tb_fft_sample_loader
//   Directed bench for fft_sample_loader with LOG2N=3 (8 points, 16 words).
//   A second instance with DROP_W=2 exercises drop-counter saturation.
module tb_fft_sample_loader;

    logic        clk;
    logic        rst;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        sample_ready;
    logic        fft_done;
    logic        fft_start;
    logic        sram_write_ena;
    logic [3:0]  sram_addr;
    logic [15:0] sram_wdata;
    logic        bus_owner;
    logic        busy;
    logic [7:0]  drop_count;

    logic        rst2;
    logic        valid2;
    logic        ready2;
    logic        done2;
    logic        start2;
    logic        we2;
    logic [3:0]  addr2;
    logic [15:0] wdata2;
    logic        owner2;
    logic        busy2;
    logic [1:0]  drop2;

    fft_sample_loader #(.LOG2N(3), .ADDR_W(4), .DATA_W(16), .DROP_W(8)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .sample_in      (sample_in),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .fft_done       (fft_done),
        .fft_start      (fft_start),
        .sram_write_ena (sram_write_ena),
        .sram_addr      (sram_addr),
        .sram_wdata     (sram_wdata),
        .bus_owner      (bus_owner),
        .busy           (busy),
        .drop_count     (drop_count)
    );

    fft_sample_loader #(.LOG2N(3), .ADDR_W(4), .DATA_W(16), .DROP_W(2)) u_dut_sat (
        .clk            (clk),
        .rst            (rst2),
        .sample_in      (sample_in),
        .sample_valid   (valid2),
        .sample_ready   (ready2),
        .fft_done       (done2),
        .fft_start      (start2),
        .sram_write_ena (we2),
        .sram_addr      (addr2),
        .sram_wdata     (wdata2),
        .bus_owner      (owner2),
        .busy           (busy2),
        .drop_count     (drop2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Expected bit-reversed write order for 8 points.
    int exp_addr [16] = '{0, 1, 8, 9, 4, 5, 12, 13, 2, 3, 10, 11, 6, 7, 14, 15};

    // Write / start monitor
    int          cyc = 0;
    int          wr_n = 0;
    int          bad_wr = 0;
    int          start_n = 0;
    int          start_gap = 0;
    int          last_wr_cyc = 0;
    logic [3:0]  wr_addr [64];
    logic [15:0] wr_data [64];
    int          wr_cyc  [64];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sram_write_ena) begin
            if (!bus_owner) bad_wr = bad_wr + 1;
            if (wr_n < 64) begin
                wr_addr[wr_n] = sram_addr;
                wr_data[wr_n] = sram_wdata;
                wr_cyc[wr_n]  = cyc;
            end
            wr_n        = wr_n + 1;
            last_wr_cyc = cyc;
        end
        if (fft_start) begin
            start_n   = start_n + 1;
            start_gap = cyc - last_wr_cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Offer one sample and return at posedge+1 of the edge that took it.
    // sample_valid is left high so a continuous stream stays continuous.
    task automatic send(input logic [15:0] d, input bit gaps);
        int unsigned t = 0;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                sample_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        sample_in    = d;
        sample_valid = 1'b1;
        @(negedge clk);
        while (!sample_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (t >= 40) check("send_timeout", 32'(t), 0);
        @(posedge clk); #1;
    endtask

    task automatic wait_start();
        int unsigned t = 0;
        @(negedge clk);
        while (!fft_start && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("start_seen", 32'(fft_start), 1);
        check("owner_at_start", 32'(bus_owner), 0);
        check("busy_at_start", 32'(busy), 1);
        check("ready_at_start", 32'(sample_ready), 0);
        @(posedge clk); #1;
    endtask

    task automatic check_frame(input logic [15:0] base, input bit contiguous);
        logic [15:0] ed;
        check("wr_count", 32'(wr_n), 16);
        for (int i = 0; i < 16; i++) begin
            ed = (i % 2 == 1) ? 16'h0 : 16'(base + 16'(i / 2));
            check("wr_addr", 32'(wr_addr[i]), 32'(exp_addr[i]));
            check("wr_data", 32'(wr_data[i]), 32'(ed));
            if (contiguous && i > 0) check("wr_spacing", 32'(wr_cyc[i] - wr_cyc[i-1]), 1);
        end
        check("start_gap", 32'(start_gap), 1);
    endtask

    task automatic pulse_done();
        fft_done = 1'b1;
        @(posedge clk); #1;
        fft_done = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, 32'(sample_ready), 1);
        check({tag, "_start"}, 32'(fft_start), 0);
        check({tag, "_we"},    32'(sram_write_ena), 0);
        check({tag, "_addr"},  32'(sram_addr), 0);
        check({tag, "_wdata"}, 32'(sram_wdata), 0);
        check({tag, "_owner"}, 32'(bus_owner), 1);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_drop"},  32'(drop_count), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        sample_in    = '0;
        sample_valid = 1'b0;
        fft_done     = 1'b0;
        rst2         = 1'b1;
        valid2       = 1'b1;
        done2        = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst");
        check("rst2_drop", 32'(drop2), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Frame 1: continuous stream 1..8
        wr_n = 0;
        for (int k = 0; k < 8; k++) send(16'(k + 1), 1'b0);
        sample_valid = 1'b0;
        wait_start();
        check("start_n_f1", 32'(start_n), 1);
        check_frame(16'h0001, 1'b1);

        // Drops while waiting for the core
        sample_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("ready_busy", 32'(sample_ready), 0);
            @(posedge clk); #1;
        end
        sample_valid = 1'b0;
        @(negedge clk);
        check("drop_10", 32'(drop_count), 10);
        @(posedge clk); #1;
        pulse_done();
        @(negedge clk);
        check("owner_after_done", 32'(bus_owner), 1);
        check("ready_after_done", 32'(sample_ready), 1);
        check("busy_after_done", 32'(busy), 0);
        check("drop_held", 32'(drop_count), 10);
        @(posedge clk); #1;

        // fft_done while filling is ignored
        wr_n = 0;
        for (int k = 0; k < 3; k++) send(16'(16'h11 + k), 1'b0);
        sample_valid = 1'b0;
        fft_done     = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        fft_done = 1'b0;
        @(negedge clk);
        check("fill_done_busy", 32'(busy), 0);
        check("fill_done_ready", 32'(sample_ready), 1);
        check("fill_done_start_n", 32'(start_n), 1);
        @(posedge clk); #1;
        for (int k = 3; k < 8; k++) send(16'(16'h11 + k), 1'b0);
        sample_valid = 1'b0;
        wait_start();
        check("start_n_f2", 32'(start_n), 2);
        check_frame(16'h0011, 1'b0);
        pulse_done();

        // Reset in the middle of a frame
        for (int k = 0; k < 5; k++) send(16'(16'h21 + k), 1'b0);
        sample_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_vals("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_start_n", 32'(start_n), 2);
        wr_n = 0;
        for (int k = 0; k < 8; k++) send(16'(16'h31 + k), 1'b0);
        sample_valid = 1'b0;
        wait_start();
        check("start_n_f3", 32'(start_n), 3);
        check_frame(16'h0031, 1'b1);
        pulse_done();

        // Two back-to-back frames with random valid gaps
        for (int f = 0; f < 2; f++) begin
            wr_n = 0;
            for (int k = 0; k < 8; k++) send(16'(16'h41 + 16 * f + k), 1'b1);
            sample_valid = 1'b0;
            wait_start();
            check("start_n_gap", 32'(start_n), 32'(4 + f));
            check_frame(16'(16'h41 + 16 * f), 1'b0);
            pulse_done();
        end
        check("bad_writes", 32'(bad_wr), 0);

        // DROP_W=2 saturation: valid held high through fill and busy
        rst2 = 1'b0;
        repeat (18) @(posedge clk);
        @(negedge clk);
        check("sat_drop_2", 32'(drop2), 2);
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("sat_drop_3", 32'(drop2), 3);
        check("sat_busy", 32'(busy2), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
